clip_controller: RTL and testbench
==================================

// Module: clip_controller
// PURPOSE
// - N-clip record/playback sequencer for the PDM-mic -> BRAM -> PWM audio path.
// - Successor to the 2-clip controller. Scales to CLIP_COUNT clips and folds the address counter and timer in.
// - Tracks the recorded length of each clip, so playback stops at the true end of the clip.
// - Adds a stop command. Sits between the button synchronizers and the serializer, deserializer and BRAM blocks.
// PARAMETERS
// - CLIP_COUNT  2       number of clip memories (>=2); CLIP_BITS = $clog2(CLIP_COUNT)
// - ADDR_WIDTH  17      sample address width of each clip memory
// - CLIP_DEPTH  100000  max samples per clip (<= 2**ADDR_WIDTH)
// PORTS
// - clock_i                 in   1           system clock
// - reset_n_i               in   1           async active-low reset
// - play_command_i          in   1           synchronized play button (level)
// - record_command_i        in   1           synchronized record button (level)
// - stop_command_i          in   1           synchronized stop button (level)
// - play_clip_select_i      in   CLIP_BITS   clip to play
// - record_clip_select_i    in   CLIP_BITS   clip to record
// - playing_o               out  1           high in PLAY
// - recording_o             out  1           high in RECORD
// - play_clip_o             out  CLIP_BITS   latched active play clip
// - record_clip_o           out  CLIP_BITS   latched active record clip
// - serializer_enable_o     out  1           run PWM serializer
// - serializer_done_i       in   1           1-cycle pulse: sample consumed
// - deserializer_enable_o   out  1           run PDM deserializer
// - deserializer_done_i     in   1           1-cycle pulse: sample ready
// - memory_enable_o         out  CLIP_COUNT  one-hot BRAM enable
// - memory_rw_o             out  1           1 = write strobe
// - memory_address_o        out  ADDR_WIDTH  sample address
// - clip_valid_o            out  CLIP_COUNT  clip holds >=1 recorded sample
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, all lengths 0, clip_valid_o = 0. Outputs are registered.
// - Commands act on a rising edge of the level (registered previous value).
// - Same-cycle command edges: priority stop > record > play.
// - Select index >= CLIP_COUNT: command ignored.
// - States: IDLE, RECORD, PLAY.
// - IDLE -> RECORD on record edge:
//   - latch record_clip_o, address = 0, clear valid/length of that clip;
//   - deserializer_enable_o = 1, memory_enable_o one-hot on that clip.
// - RECORD write timing:
//   - deserializer_done_i at cycle t -> memory_rw_o = 1 at t+1 (addr unchanged);
//   - at t+2: rw = 0, address +1, length +1, clip valid set.
// - RECORD -> IDLE:
//   - after the write at address CLIP_DEPTH-1 completes; or
//   - on a stop edge or record edge; an in-flight write strobe still completes first.
// - IDLE -> PLAY on play edge, only if clip_valid_o[sel] = 1 (else ignored):
//   - address = 0, serializer_enable_o = 1, rw = 0.
// - PLAY stepping:
//   - serializer_done_i pulse -> address +1 next cycle (BRAM read latency 1);
//   - pulse at address length-1 -> IDLE.
// - In PLAY: record edge -> abort play and enter RECORD (same rules); stop edge -> IDLE; play edge -> restart at 0.
// - Stray done pulses in IDLE, or the non-matching done in a state, are ignored.
// - Async reset mid-operation: immediate return to reset values; lengths are lost.
// - Recording the clip being played is allowed only via abort; no simultaneous play and record.
// CONFIGURATION
// - LOOP_PLAYBACK_EN defined:
//   - end of clip in PLAY wraps address to 0 and continues until stop, record or play edge;
//   - playing_o stays high across the wrap.
// - LOOP_PLAYBACK_EN undefined: end of clip returns to IDLE (as above).
// TESTING
// 1. Reset low mid-RECORD -> all outputs 0, clip_valid_o = 0 within the same cycle.
// 2. Record clip 1, 3 deserializer_done pulses, stop ->
//    - rw strobes at addr 0,1,2;
//    - clip_valid_o = 2'b10; length 3; state IDLE.
// 3. Play clip 1 (length 3), 3 serializer_done pulses ->
//    - addr 0 -> 1 -> 2, then IDLE, playing_o = 0.
//    - With LOOP_PLAYBACK_EN: addr returns to 0, playing_o = 1.
// 4. Play edge on invalid clip 0 -> no state change, all enables stay 0.
// 5. CLIP_DEPTH = 4, record 6 pulses -> exactly 4 writes (addr 0..3), auto IDLE, length 4.
// 6. Same-cycle play + record edges in IDLE -> RECORD entered; play ignored.

Source files
------------

// File: rtl/clip_controller.sv
// rtl/clip_controller.sv - N-clip record/playback sequencer for the PDM -> BRAM -> PWM audio path.
// Optional feature: define LOOP_PLAYBACK_EN to wrap playback at end of clip instead of returning to idle.
module clip_controller #(
    parameter int CLIP_COUNT = 2,
    parameter int ADDR_WIDTH = 17,
    parameter int CLIP_DEPTH = 100000,
    localparam int CLIP_BITS = $clog2(CLIP_COUNT)
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  play_command_i,
    input  logic                  record_command_i,
    input  logic                  stop_command_i,
    input  logic [CLIP_BITS-1:0]  play_clip_select_i,
    input  logic [CLIP_BITS-1:0]  record_clip_select_i,
    output logic                  playing_o,
    output logic                  recording_o,
    output logic [CLIP_BITS-1:0]  play_clip_o,
    output logic [CLIP_BITS-1:0]  record_clip_o,
    output logic                  serializer_enable_o,
    input  logic                  serializer_done_i,
    output logic                  deserializer_enable_o,
    input  logic                  deserializer_done_i,
    output logic [CLIP_COUNT-1:0] memory_enable_o,
    output logic                  memory_rw_o,
    output logic [ADDR_WIDTH-1:0] memory_address_o,
    output logic [CLIP_COUNT-1:0] clip_valid_o
);

    typedef enum logic [1:0] {IDLE, RECORD, PLAY} state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(CLIP_DEPTH);

    state_t                state;
    logic                  play_prev, record_prev, stop_prev;
    logic                  play_edge, record_edge, stop_edge;
    logic                  record_sel_ok, play_sel_ok;
    logic                  record_go, play_go;
    logic                  do_record, do_play, do_idle;
    logic                  play_last;
    logic [ADDR_WIDTH:0]   addr_next;
    logic [ADDR_WIDTH:0]   clip_length [CLIP_COUNT];
    logic [CLIP_COUNT-1:0] record_onehot, play_onehot;

    assign play_edge   = play_command_i & ~play_prev;
    assign record_edge = record_command_i & ~record_prev;
    assign stop_edge   = stop_command_i & ~stop_prev;

    assign record_sel_ok = (32'(record_clip_select_i) < CLIP_COUNT);
    assign play_sel_ok   = (32'(play_clip_select_i) < CLIP_COUNT);
    assign record_go     = record_edge && record_sel_ok;
    assign play_go       = play_edge && play_sel_ok && clip_valid_o[play_clip_select_i];

    assign record_onehot = {{(CLIP_COUNT-1){1'b0}}, 1'b1} << record_clip_select_i;
    assign play_onehot   = {{(CLIP_COUNT-1){1'b0}}, 1'b1} << play_clip_select_i;

    // Address and length share a counter: while recording, address equals the length so far.
    assign addr_next = {1'b0, memory_address_o} + {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign play_last = (addr_next >= clip_length[play_clip_o]);

    always_comb begin
        do_record = 1'b0;
        do_play   = 1'b0;
        do_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (!stop_edge) begin
                    do_record = record_go;
                    do_play   = !record_go && play_go;
                end
            end
            RECORD: begin
                // A pending write strobe finishes on this edge even when leaving.
                do_idle = stop_edge || record_edge || (memory_rw_o && (addr_next == DEPTH));
            end
            PLAY: begin
                if (stop_edge) begin
                    do_idle = 1'b1;
                end else if (record_go) begin
                    do_record = 1'b1;
                end else if (play_go) begin
                    do_play = 1'b1;
                end else if (serializer_done_i && play_last) begin
`ifdef LOOP_PLAYBACK_EN
                    do_idle = 1'b0;
`else
                    do_idle = 1'b1;
`endif
                end
            end
            default: do_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state                 <= IDLE;
            play_prev             <= 1'b0;
            record_prev           <= 1'b0;
            stop_prev             <= 1'b0;
            playing_o             <= 1'b0;
            recording_o           <= 1'b0;
            play_clip_o           <= '0;
            record_clip_o         <= '0;
            serializer_enable_o   <= 1'b0;
            deserializer_enable_o <= 1'b0;
            memory_enable_o       <= '0;
            memory_rw_o           <= 1'b0;
            memory_address_o      <= '0;
            clip_valid_o          <= '0;
            for (int i = 0; i < CLIP_COUNT; i++) begin
                clip_length[i] <= '0;
            end
        end else begin
            play_prev   <= play_command_i;
            record_prev <= record_command_i;
            stop_prev   <= stop_command_i;

            if (state == RECORD && memory_rw_o) begin
                clip_length[record_clip_o]  <= addr_next;
                clip_valid_o[record_clip_o] <= 1'b1;
            end

            if (do_record) begin
                state                              <= RECORD;
                record_clip_o                      <= record_clip_select_i;
                clip_length[record_clip_select_i]  <= '0;
                clip_valid_o[record_clip_select_i] <= 1'b0;
                memory_address_o                   <= '0;
                memory_rw_o                        <= 1'b0;
                memory_enable_o                    <= record_onehot;
                deserializer_enable_o              <= 1'b1;
                serializer_enable_o                <= 1'b0;
                recording_o                        <= 1'b1;
                playing_o                          <= 1'b0;
            end else if (do_play) begin
                state                 <= PLAY;
                play_clip_o           <= play_clip_select_i;
                memory_address_o      <= '0;
                memory_rw_o           <= 1'b0;
                memory_enable_o       <= play_onehot;
                serializer_enable_o   <= 1'b1;
                deserializer_enable_o <= 1'b0;
                playing_o             <= 1'b1;
                recording_o           <= 1'b0;
            end else if (do_idle) begin
                state                 <= IDLE;
                memory_address_o      <= '0;
                memory_rw_o           <= 1'b0;
                memory_enable_o       <= '0;
                serializer_enable_o   <= 1'b0;
                deserializer_enable_o <= 1'b0;
                playing_o             <= 1'b0;
                recording_o           <= 1'b0;
            end else begin
                case (state)
                    RECORD: begin
                        if (memory_rw_o) begin
                            memory_rw_o      <= 1'b0;
                            memory_address_o <= addr_next[ADDR_WIDTH-1:0];
                        end else if (deserializer_done_i) begin
                            memory_rw_o <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (serializer_done_i) begin
                            memory_address_o <= play_last ? '0 : addr_next[ADDR_WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clip_controller.sv
// tb/tb_clip_controller.sv - Self-checking bench for clip_controller (honours LOOP_PLAYBACK_EN).
module tb_clip_controller;

    localparam int NCLIP = 3;
    localparam int AW    = 3;
    localparam int DEPTH = 4;
    localparam int OW    = 18;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            play_cmd = 1'b0, rec_cmd = 1'b0, stop_cmd = 1'b0;
    logic [1:0]      play_sel = '0, rec_sel = '0;
    logic            ser_done = 1'b0, des_done = 1'b0;
    logic            playing, recording, ser_en, des_en, mem_rw;
    logic [1:0]      play_clip, rec_clip;
    logic [NCLIP-1:0] mem_en, clip_valid;
    logic [AW-1:0]   mem_addr;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference state: mode 0 idle, 1 record, 2 play; a clip is valid when its length is non-zero.
    int m_mode, m_addr, m_pclip, m_rclip;
    int m_len [NCLIP];
    bit m_wr, m_pprev, m_rprev, m_sprev;

    clip_controller #(.CLIP_COUNT(NCLIP), .ADDR_WIDTH(AW), .CLIP_DEPTH(DEPTH)) dut (
        .clock_i(clk), .reset_n_i(reset_n),
        .play_command_i(play_cmd), .record_command_i(rec_cmd), .stop_command_i(stop_cmd),
        .play_clip_select_i(play_sel), .record_clip_select_i(rec_sel),
        .playing_o(playing), .recording_o(recording),
        .play_clip_o(play_clip), .record_clip_o(rec_clip),
        .serializer_enable_o(ser_en), .serializer_done_i(ser_done),
        .deserializer_enable_o(des_en), .deserializer_done_i(des_done),
        .memory_enable_o(mem_en), .memory_rw_o(mem_rw), .memory_address_o(mem_addr),
        .clip_valid_o(clip_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] dut_out();
        return {playing, recording, play_clip, rec_clip, ser_en, des_en, mem_en, mem_rw, mem_addr, clip_valid};
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic [NCLIP-1:0] en, val;
        en = '0;
        val = '0;
        for (int i = 0; i < NCLIP; i++) val[i] = (m_len[i] > 0);
        if (m_mode == 1) en[m_rclip] = 1'b1;
        else if (m_mode == 2) en[m_pclip] = 1'b1;
        return {m_mode == 2, m_mode == 1, 2'(m_pclip), 2'(m_rclip), m_mode == 2, m_mode == 1,
                en, m_wr, 3'(m_addr), val};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_addr = 0; m_pclip = 0; m_rclip = 0; m_wr = 0;
        m_pprev = 0; m_rprev = 0; m_sprev = 0;
        for (int i = 0; i < NCLIP; i++) m_len[i] = 0;
    endtask

    task automatic go_idle();
        m_mode = 0; m_addr = 0; m_wr = 0;
    endtask

    task automatic start_record();
        m_mode = 1; m_rclip = int'(rec_sel); m_len[rec_sel] = 0; m_addr = 0; m_wr = 0;
    endtask

    task automatic start_play();
        m_mode = 2; m_pclip = int'(play_sel); m_addr = 0; m_wr = 0;
    endtask

    task automatic model_clock();
        bit pe, re, se, r_ok, p_ok;
        pe = play_cmd && !m_pprev;
        re = rec_cmd && !m_rprev;
        se = stop_cmd && !m_sprev;
        m_pprev = play_cmd; m_rprev = rec_cmd; m_sprev = stop_cmd;
        r_ok = (int'(rec_sel) < NCLIP);
        p_ok = (int'(play_sel) < NCLIP) && (m_len[play_sel] > 0);
        case (m_mode)
            0: if (!se) begin
                if (re && r_ok) start_record();
                else if (pe && p_ok) start_play();
            end
            1: if (m_wr) begin
                m_wr = 0;
                m_len[m_rclip]++;
                m_addr++;
                if (se || re || m_len[m_rclip] == DEPTH) go_idle();
            end else if (se || re) go_idle();
            else if (des_done) m_wr = 1;
            default: begin
                if (se) go_idle();
                else if (re && r_ok) start_record();
                else if (pe && p_ok) start_play();
                else if (ser_done) begin
                    if (m_addr + 1 >= m_len[m_pclip]) begin
`ifdef LOOP_PLAYBACK_EN
                        m_addr = 0;
`else
                        go_idle();
`endif
                    end else m_addr++;
                end
            end
        endcase
    endtask

    task automatic step(input bit p, input bit r, input bit s, input logic [1:0] ps,
                        input logic [1:0] rs, input bit sd, input bit dd);
        @(negedge clk);
        play_cmd = p; rec_cmd = r; stop_cmd = s;
        play_sel = ps; rec_sel = rs; ser_done = sd; des_done = dd;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_out() !== '0) begin
            n_fail++; $display("FAIL reset_state: got %b want %b", dut_out(), {OW{1'b0}});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (dut_out() !== model_out()) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want %b", dut_out(), model_out());
        end
    endtask

    task automatic test_async_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        n_cmp++;
        if ({recording, mem_rw, clip_valid} !== {1'b1, 1'b1, 3'b001}) begin
            n_fail++; $display("FAIL async_setup: got %b want %b", {recording, mem_rw, clip_valid}, 5'b11001);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_out() !== '0) begin
            n_fail++; $display("FAIL async_reset: got %b want %b", dut_out(), {OW{1'b0}});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_record_stop();
        step(0, 1, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({recording, playing, rec_clip, des_en, ser_en, mem_en} !== {1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 3'b010}) begin
            n_fail++; $display("FAIL record_enter: got %b", {recording, playing, rec_clip, des_en, ser_en, mem_en});
        end
        step(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 0, 1);
            n_cmp++;
            if ({mem_rw, mem_addr} !== {1'b1, 3'(k)}) begin
                n_fail++; $display("FAIL record_strobe%0d: got rw=%b addr=%0d want rw=1 addr=%0d", k, mem_rw, mem_addr, k);
            end
            step(0, 0, 0, 0, 1, 0, 0);
            n_cmp++;
            if ({mem_rw, mem_addr} !== {1'b0, 3'(k + 1)}) begin
                n_fail++; $display("FAIL record_advance%0d: got rw=%b addr=%0d want rw=0 addr=%0d", k, mem_rw, mem_addr, k + 1);
            end
        end
        step(0, 0, 1, 0, 1, 0, 0);
        n_cmp++;
        if ({recording, des_en, mem_en, clip_valid} !== {1'b0, 1'b0, 3'b000, 3'b010}) begin
            n_fail++; $display("FAIL record_stop: got %b want %b", {recording, des_en, mem_en, clip_valid}, 8'b00000010);
        end
        step(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_play_end();
        step(1, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({playing, ser_en, mem_en, mem_addr, play_clip} !== {1'b1, 1'b1, 3'b010, 3'd0, 2'd1}) begin
            n_fail++; $display("FAIL play_enter: got %b", {playing, ser_en, mem_en, mem_addr, play_clip});
        end
        step(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0, 1, 0);
            if (k < 2) begin
                n_cmp++;
                if ({playing, mem_addr} !== {1'b1, 3'(k + 1)}) begin
                    n_fail++; $display("FAIL play_step%0d: got playing=%b addr=%0d want 1/%0d", k, playing, mem_addr, k + 1);
                end
            end
        end
        n_cmp++;
`ifdef LOOP_PLAYBACK_EN
        if ({playing, ser_en, mem_addr} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++; $display("FAIL play_wrap: got %b want %b", {playing, ser_en, mem_addr}, 5'b11000);
        end
`else
        if ({playing, ser_en, mem_addr} !== {1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL play_end: got %b want %b", {playing, ser_en, mem_addr}, 5'b00000);
        end
`endif
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_invalid_select();
        step(1, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({playing, recording, ser_en, des_en, mem_en} !== 7'b0) begin
            n_fail++; $display("FAIL play_invalid_clip: got %b want 0000000", {playing, recording, ser_en, des_en, mem_en});
        end
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 3, 0, 0);
        n_cmp++;
        if ({recording, des_en, mem_en, clip_valid} !== {1'b0, 1'b0, 3'b000, 3'b010}) begin
            n_fail++; $display("FAIL record_bad_index: got %b", {recording, des_en, mem_en, clip_valid});
        end
        step(0, 0, 0, 0, 3, 0, 0);
    endtask

    task automatic test_depth_limit();
        int writes;
        writes = 0;
        step(0, 1, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 2, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 0, 0, 2, 0, 1);
            if (mem_rw === 1'b1) begin
                n_cmp++;
                if (mem_addr !== 3'(writes)) begin
                    n_fail++; $display("FAIL depth_write_addr: got %0d want %0d", mem_addr, writes);
                end
                writes++;
            end
            step(0, 0, 0, 0, 2, 0, 0);
        end
        n_cmp++;
        if (writes !== DEPTH) begin
            n_fail++; $display("FAIL depth_write_count: got %0d want %0d", writes, DEPTH);
        end
        n_cmp++;
        if ({recording, des_en, clip_valid} !== {1'b0, 1'b0, 3'b110}) begin
            n_fail++; $display("FAIL depth_auto_idle: got %b want 00110", {recording, des_en, clip_valid});
        end
        step(1, 0, 0, 2, 0, 0, 0);
        step(0, 0, 0, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 2, 0, 1, 0);
        n_cmp++;
        if ({playing, mem_addr} !== {1'b1, 3'd3}) begin
            n_fail++; $display("FAIL depth_play_len: got playing=%b addr=%0d want 1/3", playing, mem_addr);
        end
        step(0, 0, 0, 2, 0, 1, 0);
        n_cmp++;
`ifdef LOOP_PLAYBACK_EN
        if ({playing, mem_addr} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL depth_play_wrap: got playing=%b addr=%0d want 1/0", playing, mem_addr);
        end
`else
        if ({playing, mem_addr} !== {1'b0, 3'd0}) begin
            n_fail++; $display("FAIL depth_play_end: got playing=%b addr=%0d want 0/0", playing, mem_addr);
        end
`endif
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 2, 0, 0, 0);
    endtask

    task automatic test_same_cycle();
        step(1, 1, 0, 1, 0, 0, 0);
        n_cmp++;
        if ({recording, playing, ser_en, des_en, rec_clip, mem_en} !== {1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 3'b001}) begin
            n_fail++; $display("FAIL same_cycle_priority: got %b", {recording, playing, ser_en, des_en, rec_clip, mem_en});
        end
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        n_cmp++;
        if (dut_out() !== model_out()) begin
            n_fail++; $display("FAIL same_cycle_model: got %b want %b", dut_out(), model_out());
        end
    endtask

    task automatic test_random();
        bit p, r, s;
        p = 0; r = 0; s = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) p = !p;
            if ($urandom_range(0, 6) == 0) r = !r;
            if ($urandom_range(0, 9) == 0) s = !s;
            step(p, r, s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_cmp++;
            if (dut_out() !== model_out()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %b want %b", i, dut_out(), model_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_async_reset();
        test_record_stop();
        test_play_end();
        test_invalid_select();
        test_depth_limit();
        test_same_cycle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
